cordic_sincos_reconstruct: RTL and testbench

Iterative CORDIC engine that consumes the (quadrant, fraction) pair produced by the Payne-Hanek argument reducer and reconstructs signed sin and cos of the original angle. It rotates the reduced angle, then re-applies the quadrant through swap and negate. It sits between the reducer output and the TinyQV peripheral register file, behind a valid/ready handshake on both sides.

---
 rtl/cordic_pkg.sv | 74 +++++++
 rtl/cordic_sincos_reconstruct_if.sv | 29 ++
 rtl/cordic_quadrant_map.sv | 30 +++
 rtl/cordic_sincos_reconstruct.sv | 127 ++++++++++++
 tb/tb_cordic_sincos_reconstruct.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sin/cos reconstruction engine.
// Holds the datapath widths, the FSM state encoding, the arctangent table
// (units of 2^-32 quarter turn) and the CORDIC gain constant for each
// supported iteration count.
package cordic_pkg;

  localparam int unsigned DataW = 32;  // Q2.30 sin/cos/x/y
  localparam int unsigned FracW = 30;
  localparam int unsigned ZW    = 34;  // signed residual angle
  localparam int unsigned IdxW  = 5;   // iteration index, 0..29

  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StRotate = 2'd1;
  localparam state_t StDone   = 2'd2;

  // atan(2^-i) / (pi/2) * 2^32, rounded to nearest.
  function automatic logic [31:0] atan_lut(input logic [IdxW-1:0] idx);
    logic [31:0] val;
    case (idx)
      5'd0:    val = 32'h8000_0000;
      5'd1:    val = 32'h4B90_147C;
      5'd2:    val = 32'h27EC_E16D;
      5'd3:    val = 32'h1444_4750;
      5'd4:    val = 32'h0A2C_350C;
      5'd5:    val = 32'h0517_5F85;
      5'd6:    val = 32'h028B_D879;
      5'd7:    val = 32'h0145_F154;
      5'd8:    val = 32'h00A2_F94D;
      5'd9:    val = 32'h0051_7CBB;
      5'd10:   val = 32'h0028_BE60;
      5'd11:   val = 32'h0014_5F30;
      5'd12:   val = 32'h000A_2F98;
      5'd13:   val = 32'h0005_17CC;
      5'd14:   val = 32'h0002_8BE6;
      5'd15:   val = 32'h0001_45F3;
      5'd16:   val = 32'h0000_A2FA;
      5'd17:   val = 32'h0000_517D;
      5'd18:   val = 32'h0000_28BE;
      5'd19:   val = 32'h0000_145F;
      5'd20:   val = 32'h0000_0A30;
      5'd21:   val = 32'h0000_0518;
      5'd22:   val = 32'h0000_028C;
      5'd23:   val = 32'h0000_0146;
      5'd24:   val = 32'h0000_00A3;
      5'd25:   val = 32'h0000_0051;
      5'd26:   val = 32'h0000_0029;
      5'd27:   val = 32'h0000_0014;
      5'd28:   val = 32'h0000_000A;
      5'd29:   val = 32'h0000_0005;
      default: val = 32'h0000_0000;
    endcase
    return val;
  endfunction

  // Product of 1/sqrt(1+2^-2i) over the iterations actually run, in Q2.30.
  // Beyond 16 iterations the product no longer moves at this precision.
  function automatic logic [31:0] gain_for(input int unsigned iter);
    logic [31:0] val;
    case (iter)
      8:       val = 32'd652039507;
      9:       val = 32'd652034533;
      10:      val = 32'd652033289;
      11:      val = 32'd652032978;
      12:      val = 32'd652032900;
      13:      val = 32'd652032881;
      14:      val = 32'd652032876;
      15:      val = 32'd652032875;
      default: val = 32'h26DD_3B6A;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_sincos_reconstruct_if.sv
// Valid/ready bundle between the argument reducer, the CORDIC engine and
// the register file.
//   in_valid/in_ready/q_in/f_in     : request side (reducer -> engine)
//   out_valid/out_ready/sin_out/cos_out : result side (engine -> consumer)
// master: the environment driving requests and taking results.
// slave : the engine.
interface cordic_sincos_reconstruct_if;
  import cordic_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       q_in;
  logic [31:0]      f_in;
  logic             out_valid;
  logic             out_ready;
  logic [DataW-1:0] sin_out;
  logic [DataW-1:0] cos_out;

  modport master (
    output in_valid, q_in, f_in, out_ready,
    input  in_ready, out_valid, sin_out, cos_out
  );

  modport slave (
    input  in_valid, q_in, f_in, out_ready,
    output in_ready, out_valid, sin_out, cos_out
  );

endinterface

// File: rtl/cordic_quadrant_map.sv
// Combinational quadrant re-application: maps the rotated first-quadrant
// vector (x, y) to (sin, cos) of the full angle by swap and negate.
//   q_i   : quadrant 0..3
//   x_i   : rotated x (cos of reduced angle), Q2.30
//   y_i   : rotated y (sin of reduced angle), Q2.30
//   sin_o : sin of full angle, Q2.30
//   cos_o : cos of full angle, Q2.30
module cordic_quadrant_map
  import cordic_pkg::*;
(
  input  logic [1:0]              q_i,
  input  logic signed [DataW-1:0] x_i,
  input  logic signed [DataW-1:0] y_i,
  output logic signed [DataW-1:0] sin_o,
  output logic signed [DataW-1:0] cos_o
);

  // |x|,|y| stay near 1.0 in Q2.30, so negation can never wrap.
  always_comb begin
    sin_o = y_i;
    cos_o = x_i;
    unique case (q_i)
      2'd0: begin sin_o = y_i;  cos_o = x_i;  end
      2'd1: begin sin_o = x_i;  cos_o = -y_i; end
      2'd2: begin sin_o = -y_i; cos_o = -x_i; end
      2'd3: begin sin_o = -x_i; cos_o = y_i;  end
    endcase
  end

endmodule

// File: rtl/cordic_sincos_reconstruct.sv
// Iterative CORDIC engine: takes (quadrant, Q0.32 quarter-turn fraction)
// from the argument reducer, rotates the fraction over ITER cycles and
// applies the quadrant to produce signed Q2.30 sin and cos.
//   clk : clock
//   rst : synchronous reset, active-high
//   bus : slave side of cordic_sincos_reconstruct_if (request + result)
module cordic_sincos_reconstruct
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 24
) (
  input logic                        clk,
  input logic                        rst,
  cordic_sincos_reconstruct_if.slave bus
);

  localparam logic [31:0]     Gain     = gain_for(ITER);
  localparam logic [IdxW-1:0] LastIter = IdxW'(ITER - 1);

  state_t                  state_q, state_d;
  logic [1:0]              q_q, q_d;
  logic signed [DataW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]    z_q, z_d;
  logic [IdxW-1:0]         i_q, i_d;
  logic signed [DataW-1:0] sin_q, sin_d, cos_q, cos_d;

  logic signed [DataW-1:0] x_sh, y_sh, x_rot, y_rot, sin_map, cos_map;
  logic signed [ZW-1:0]    z_rot, atan_ext;
  logic                    d_pos;

  // Only the low two quadrant bits carry information.
  logic unused_q_hi;
  assign unused_q_hi = ^bus.q_in[4:2];

  // One micro-rotation; a single shifter per axis serves all iterations.
  always_comb begin
    x_sh     = x_q >>> i_q;
    y_sh     = y_q >>> i_q;
    atan_ext = {2'b00, atan_lut(i_q)};
    d_pos    = ~z_q[ZW-1];
    if (d_pos) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_ext;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_ext;
    end
  end

  // Map the final-iteration vector directly so the result registers on
  // the same edge that enters DONE.
  cordic_quadrant_map u_quadrant_map (
    .q_i  (q_q),
    .x_i  (x_rot),
    .y_i  (y_rot),
    .sin_o(sin_map),
    .cos_o(cos_map)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          q_d     = bus.q_in[1:0];
          x_d     = Gain;
          y_d     = '0;
          z_d     = {2'b00, bus.f_in};
          i_d     = '0;
          state_d = StRotate;
        end
      end
      StRotate: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + 1'b1;
        if (i_q == LastIter) begin
          sin_d   = sin_map;
          cos_d   = cos_map;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sin_out   = sin_q;
  assign bus.cos_out   = cos_q;

endmodule

// File: tb/tb_cordic_sincos_reconstruct.sv
// Directed bench for cordic_sincos_reconstruct with hand-computed targets.
module tb_cordic_sincos_reconstruct;

  localparam longint Tol = 128;
  localparam logic [31:0] One    = 32'h4000_0000;
  localparam logic [31:0] Zero   = 32'h0000_0000;
  localparam logic [31:0] Rt2Pos = 32'h2D41_3CCD;
  localparam logic [31:0] Rt2Neg = 32'hD2BE_C333;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  cordic_sincos_reconstruct_if bus ();

  cordic_sincos_reconstruct #(.ITER(24)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint adiff(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    if (d < 0) d = -d;
    return d;
  endfunction

  // Issue one request and wait (bounded) for out_valid; lat counts edges
  // after the accepting edge.
  task automatic send(input logic [4:0] q, input logic [31:0] f, output int lat);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.q_in     = q;
    bus.f_in     = f;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.sin_out !== Zero) begin
      miscompares++;
      $display("FAIL reset_sin: got %h want %h", bus.sin_out, Zero);
    end
    vectors++;
    if (bus.cos_out !== Zero) begin
      miscompares++;
      $display("FAIL reset_cos: got %h want %h", bus.cos_out, Zero);
    end
  endtask

  // Quadrant/fraction sweep: latency plus sin/cos within tolerance.
  task automatic test_angle(input string name, input logic [4:0] q, input logic [31:0] f,
                            input logic [31:0] exp_sin, input logic [31:0] exp_cos);
    int lat;
    send(q, f, lat);
    vectors++;
    if (lat !== 24) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d want 24", name, lat);
    end
    vectors++;
    if (adiff(bus.sin_out, exp_sin) > Tol) begin
      miscompares++;
      $display("FAIL %s_sin: got %h want %h +-%0d", name, bus.sin_out, exp_sin, Tol);
    end
    vectors++;
    if (adiff(bus.cos_out, exp_cos) > Tol) begin
      miscompares++;
      $display("FAIL %s_cos: got %h want %h +-%0d", name, bus.cos_out, exp_cos, Tol);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] s0, c0;
    send(5'd0, 32'h8000_0000, lat);
    vectors++;
    if (lat !== 24 || adiff(bus.sin_out, Rt2Pos) > Tol) begin
      miscompares++;
      $display("FAIL bp_result: lat %0d sin %h want lat 24 sin %h", lat, bus.sin_out, Rt2Pos);
    end
    s0 = bus.sin_out;
    c0 = bus.cos_out;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.in_valid = 1'b1;
        bus.q_in     = 5'd2;
        bus.f_in     = 32'h0;
      end
      tick();
      bus.in_valid = 1'b0;
      vectors++;
      if (bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, bus.out_valid);
      end
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", k, bus.in_ready);
      end
      vectors++;
      if (bus.sin_out !== s0 || bus.cos_out !== c0) begin
        miscompares++;
        $display("FAIL bp_hold_data[%0d]: got %h/%h want %h/%h", k, bus.sin_out, bus.cos_out,
                 s0, c0);
      end
    end
    release_result();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release_valid: got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_no_second_accept[%0d]: got ready %b valid %b want 1/0", k,
                 bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_reset_mid_rotate();
    bus.in_valid = 1'b1;
    bus.q_in     = 5'd0;
    bus.f_in     = 32'h4000_0000;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready);
    end
    vectors++;
    if (bus.sin_out !== Zero || bus.cos_out !== Zero) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got %h/%h want 0/0", bus.sin_out, bus.cos_out);
    end
    // No stale result may surface later.
    for (int k = 0; k < 20; k++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rstmid_stale_valid[%0d]: got %b want 0", k, bus.out_valid);
      end
    end
    test_angle("rstmid_fresh", 5'd0, 32'h0, Zero, One);
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    send(5'd1, 32'h8000_0000, lat);
    vectors++;
    if (lat !== 24 || adiff(bus.sin_out, Rt2Pos) > Tol || adiff(bus.cos_out, Rt2Neg) > Tol)
    begin
      miscompares++;
      $display("FAIL b2b_first: lat %0d got %h/%h want 24 %h/%h", lat, bus.sin_out,
               bus.cos_out, Rt2Pos, Rt2Neg);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_turnaround: got valid %b ready %b want 0/1", bus.out_valid,
               bus.in_ready);
    end
    send(5'd3, 32'h8000_0000, lat);
    vectors++;
    if (lat !== 24 || adiff(bus.sin_out, Rt2Neg) > Tol || adiff(bus.cos_out, Rt2Pos) > Tol)
    begin
      miscompares++;
      $display("FAIL b2b_second: lat %0d got %h/%h want 24 %h/%h", lat, bus.sin_out,
               bus.cos_out, Rt2Neg, Rt2Pos);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.q_in      = '0;
    bus.f_in      = '0;
    bus.out_ready = 1'b0;

    test_reset();
    test_angle("q0_f0", 5'd0, 32'h0, Zero, One);
    test_angle("q0_45", 5'd0, 32'h8000_0000, Rt2Pos, Rt2Pos);
    test_angle("q2_45", 5'd2, 32'h8000_0000, Rt2Neg, Rt2Neg);
    test_angle("q5_f0", 5'd5, 32'h0, One, Zero);
    test_backpressure();
    test_reset_mid_rotate();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
